// File: rtl/piso_shift_serializer_pkg.sv
// rtl/piso_shift_serializer_pkg.sv - shared constants for the parallel-in serial-out serializer
//
// Purpose: state encoding and shift-direction codes used by the serializer
//          and by anything that drives its dir input.
// Contents:
//   state_t       : 1-bit FSM state (ST_IDLE, ST_SHIFT)
//   DIR_MSB_FIRST : dir code, shift left, bit WIDTH-1 goes out first
//   DIR_LSB_FIRST : dir code, shift right, bit 0 goes out first
package piso_shift_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_shift_serializer.sv
// rtl/piso_shift_serializer.sv - parallel word to valid/ready bit stream, MSB- or LSB-first
//
// Purpose: accepts one WIDTH-bit word per in_valid/in_ready handshake and
//          emits it one bit per ser_valid/ser_ready handshake. The shift
//          order is captured with the word and held for the whole word.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   in_valid   : upstream word present
//   in_ready   : block can accept a word (IDLE)
//   in_data    : parallel word
//   dir        : 0 = MSB-first, 1 = LSB-first; sampled at accept only
//   ser_out    : current serial bit (0 while idle)
//   ser_valid  : ser_out is meaningful (SHIFT)
//   ser_ready  : downstream takes the bit
//   last       : current bit is the final bit of the word
//   done       : one-cycle pulse the cycle after the final bit handshake
module piso_shift_serializer
    import piso_shift_serializer_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             dir,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             last,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;

    // Handshake flags and serial outputs decode straight from the state
    // register so they change only on a clock edge.
    assign in_ready  = (state == ST_IDLE);
    assign ser_valid = (state == ST_SHIFT);
    assign last      = (state == ST_SHIFT) && (cnt == CNT_LAST);

    always_comb begin
        ser_out = 1'b0;
        if (state == ST_SHIFT) begin
            ser_out = (dir_q == DIR_LSB_FIRST) ? shreg[0] : shreg[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
            dir_q <= DIR_MSB_FIRST;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        dir_q <= dir;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Without ser_ready everything holds, so ser_out is stable
                    // under backpressure. in_valid/in_data/dir are ignored here.
                    if (ser_ready) begin
                        if (dir_q == DIR_LSB_FIRST) begin
                            shreg <= shreg >> 1;
                        end else begin
                            shreg <= shreg << 1;
                        end
                        if (cnt == CNT_LAST) begin
                            // Final bit: return to IDLE; the next word can only
                            // be accepted on the following edge.
                            state <= ST_IDLE;
                            cnt   <= '0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_serializer.sv
// tb/tb_piso_shift_serializer.sv - directed self-checking bench for piso_shift_serializer
module tb_piso_shift_serializer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       dir;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_ready;
    logic       last;
    logic       done;

    int checks = 0;
    int errors = 0;

    piso_shift_serializer #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .dir       (dir),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .last      (last),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then return to the falling edge where inputs are
    // driven and outputs sampled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // A bit cycle: valid bit presented with the given value and last flag.
    task automatic bit_cycle(input string tag, input logic exp_bit, input logic exp_last);
        chk({tag, "_valid"}, ser_valid, 1'b1);
        chk({tag, "_out"}, ser_out, exp_bit);
        chk({tag, "_last"}, last, exp_last);
        chk({tag, "_inrdy"}, in_ready, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    // The cycle after the final bit handshake: idle with done pulsing.
    task automatic done_cycle(input string tag);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_inrdy"}, in_ready, 1'b1);
        chk({tag, "_valid"}, ser_valid, 1'b0);
        chk({tag, "_out"}, ser_out, 1'b0);
        chk({tag, "_last"}, last, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'b0000;
        dir       = 1'b0;
        ser_ready = 1'b1;
        @(negedge clk);
        tick();

        chk("rst_valid", ser_valid, 1'b0);
        chk("rst_out", ser_out, 1'b0);
        chk("rst_last", last, 1'b0);
        chk("rst_inrdy", in_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        tick();

        // MSB-first 1010
        in_valid = 1'b1; in_data = 4'b1010; dir = 1'b0;
        tick();
        in_valid = 1'b0;
        bit_cycle("msb_b0", 1'b1, 1'b0); tick();
        bit_cycle("msb_b1", 1'b0, 1'b0); tick();
        bit_cycle("msb_b2", 1'b1, 1'b0); tick();
        bit_cycle("msb_b3", 1'b0, 1'b1); tick();
        done_cycle("msb_end"); tick();
        chk("msb_done_clr", done, 1'b0);

        // LSB-first 0111
        in_valid = 1'b1; in_data = 4'b0111; dir = 1'b1;
        tick();
        in_valid = 1'b0;
        bit_cycle("lsb_b0", 1'b1, 1'b0); tick();
        bit_cycle("lsb_b1", 1'b1, 1'b0); tick();
        bit_cycle("lsb_b2", 1'b1, 1'b0); tick();
        bit_cycle("lsb_b3", 1'b0, 1'b1); tick();
        done_cycle("lsb_end"); tick();

        // Backpressure on the second bit
        in_valid = 1'b1; in_data = 4'b1010; dir = 1'b0;
        tick();
        in_valid = 1'b0;
        bit_cycle("bp_b0", 1'b1, 1'b0); tick();
        ser_ready = 1'b0;
        bit_cycle("bp_hold0", 1'b0, 1'b0); tick();
        bit_cycle("bp_hold1", 1'b0, 1'b0); tick();
        ser_ready = 1'b1;
        bit_cycle("bp_hold2", 1'b0, 1'b0); tick();
        bit_cycle("bp_b2", 1'b1, 1'b0); tick();
        bit_cycle("bp_b3", 1'b0, 1'b1); tick();
        done_cycle("bp_end"); tick();

        // Back-to-back with in_valid held high
        in_valid = 1'b1; in_data = 4'b1010; dir = 1'b0;
        tick();
        in_data = 4'b0111;
        bit_cycle("b2b_w0b0", 1'b1, 1'b0); tick();
        bit_cycle("b2b_w0b1", 1'b0, 1'b0); tick();
        bit_cycle("b2b_w0b2", 1'b1, 1'b0); tick();
        bit_cycle("b2b_w0b3", 1'b0, 1'b1); tick();
        done_cycle("b2b_gap"); tick();
        in_valid = 1'b0;
        bit_cycle("b2b_w1b0", 1'b0, 1'b0); tick();
        bit_cycle("b2b_w1b1", 1'b1, 1'b0); tick();
        bit_cycle("b2b_w1b2", 1'b1, 1'b0); tick();
        bit_cycle("b2b_w1b3", 1'b1, 1'b1); tick();
        done_cycle("b2b_end"); tick();

        // Reset after the second bit handshake; in_valid during reset is ignored
        in_valid = 1'b1; in_data = 4'b1010; dir = 1'b0;
        tick();
        in_valid = 1'b0;
        bit_cycle("rm_b0", 1'b1, 1'b0); tick();
        bit_cycle("rm_b1", 1'b0, 1'b0); tick();
        rst_n = 1'b0;
        in_valid = 1'b1; in_data = 4'b0111; dir = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("rm_valid", ser_valid, 1'b0);
        chk("rm_inrdy", in_ready, 1'b1);
        chk("rm_last", last, 1'b0);
        chk("rm_done", done, 1'b0);
        chk("rm_out", ser_out, 1'b0);
        tick();
        in_valid = 1'b0;
        bit_cycle("rm_n_b0", 1'b1, 1'b0); tick();
        bit_cycle("rm_n_b1", 1'b1, 1'b0); tick();
        bit_cycle("rm_n_b2", 1'b1, 1'b0); tick();
        bit_cycle("rm_n_b3", 1'b0, 1'b1); tick();
        done_cycle("rm_n_end"); tick();

        // in_data, dir and in_valid changes during SHIFT have no effect
        in_valid = 1'b1; in_data = 4'b1010; dir = 1'b0;
        tick();
        in_data = 4'b1111; dir = 1'b1;
        bit_cycle("ign_b0", 1'b1, 1'b0); tick();
        dir = 1'b0;
        bit_cycle("ign_b1", 1'b0, 1'b0); tick();
        dir = 1'b1;
        bit_cycle("ign_b2", 1'b1, 1'b0); tick();
        in_valid = 1'b0;
        bit_cycle("ign_b3", 1'b0, 1'b1); tick();
        done_cycle("ign_end"); tick();
        chk("ign_idle_valid", ser_valid, 1'b0);
        chk("ign_idle_done", done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_shift_serializer.md
Name: piso_shift_serializer

Overview:
- Downstream consumer of the 4-bit logical shift stage.
- Accepts one parallel word per handshake and emits it one bit per cycle on a valid/ready serial port.
- Shift order is selectable per word: MSB-first (left shift) or LSB-first (right shift).
- Feeds a serial link or bit-level checker downstream.

Parameters:
- WIDTH, 4, parallel word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, never overridden.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, reset: one clock, synchronous, active-low.
- in_valid, input, 1, upstream word present.
- in_ready, output, 1, block can accept a word.
- in_data, input, WIDTH, parallel word, e.g. the lshift or rshift result.
- dir, input, 1, 0 = MSB-first (shift left), 1 = LSB-first (shift right); sampled only at accept.
- ser_out, output, 1, current serial bit.
- ser_valid, output, 1, ser_out is meaningful.
- ser_ready, input, 1, downstream takes the bit.
- last, output, 1, current bit is the final bit of the word.
- done, output, 1, one-cycle pulse the cycle after the final bit handshake.

Behaviour:
- States: IDLE, SHIFT; encoding is 1 bit.
- Reset: rst_n low at a rising edge forces the following values:
  - state = IDLE
  - shreg = 0, cnt = 0, dir_q = 0
  - done = 0
  - Outputs after that edge: ser_valid = 0, ser_out = 0, last = 0, in_ready = 1.
- in_ready = (state == IDLE). ser_valid = (state == SHIFT). Both are decoded combinationally from the state register.
- ser_out:
  - dir_q = 0: shreg[WIDTH-1]
  - dir_q = 1: shreg[0]
  - Forced to 0 in IDLE.
- last = (state == SHIFT) && (cnt == WIDTH-1).
- Accept: in_valid && in_ready at an edge loads:
  - shreg <= in_data, dir_q <= dir, cnt <= 0, state <= SHIFT.
  - The first bit is valid in the cycle after accept, so latency is 1 cycle.
- Bit handshake: ser_valid && ser_ready at an edge:
  - dir_q = 0: shreg <= shreg << 1, zero fill.
  - dir_q = 1: shreg <= shreg >> 1, zero fill.
  - cnt <= cnt + 1.
  - If last: state <= IDLE, cnt <= 0, done <= 1 for exactly one cycle.
- Backpressure: ser_ready low holds shreg, cnt and ser_out unchanged. There is no timeout.
- in_valid and in_data during SHIFT are ignored, and in_ready = 0. Upstream must hold its word.
- Throughput:
  - With ser_ready tied high, each word takes WIDTH+1 cycles: WIDTH bit cycles plus one IDLE accept cycle.
  - There is no accept in the same cycle as the final bit handshake.
- Reset mid-word aborts the word. The partial word is discarded, no done pulse is issued, and the first cycle after reset is IDLE.
- in_valid arriving in the same cycle rst_n is low is ignored.
- dir is never re-sampled mid-word. A dir change during SHIFT has no effect.
- cnt never exceeds WIDTH-1. The wrap back to 0 happens only through the last-handshake path.

Decomposition:
- Shared package holds:
  - state localparams: ST_IDLE = 1'b0, ST_SHIFT = 1'b1
  - direction localparams: DIR_MSB_FIRST = 1'b0, DIR_LSB_FIRST = 1'b1
- Single module; no sub-module is warranted. The shift register, counter and FSM are all within one always block set.

Test Plan:
- MSB-first, ser_ready high: in_data = 4'b1010, dir = 0, one-cycle in_valid.
  - Expect ser_out 1,0,1,0 on cycles +1..+4.
  - last high on +4 only; done high on +5; in_ready back to 1 on +5.
- LSB-first, ser_ready high: in_data = 4'b0111, dir = 1.
  - Expect ser_out 1,1,1,0.
  - last on the 4th bit; done one cycle later.
- Backpressure: word 4'b1010, dir = 0, ser_ready low for 2 cycles while the second bit (0) is presented.
  - Expect ser_out = 0 and ser_valid = 1 held for 3 cycles total.
  - Sequence otherwise unchanged; done delayed by 2 cycles.
- Back-to-back: in_valid held high, in_data 4'b1010 then 4'b0111, dir = 0.
  - Expect stream 1,0,1,0, then one idle cycle with ser_valid = 0, then 0,1,1,1.
  - 10 cycles for 2 words.
- Reset mid-word: 4'b1010 accepted, rst_n low for 1 cycle after the 2nd bit.
  - Expect ser_valid = 0, in_ready = 1, last = 0 and done = 0 after that edge.
  - Next word 4'b0111 with dir = 1 serialises cleanly as 1,1,1,0.
- Ignored inputs: in_data changed to 4'b1111 and dir toggled during SHIFT of 4'b1010 with dir = 0.
  - Expect output stream still 1,0,1,0.
